// File: rtl/i2s_pkg.sv
// i2s_pkg: shared mode and FSM state types for the I2S frame-sync generator.
package i2s_pkg;
    typedef enum logic [1:0] {
        DSP_SHORT = 2'd0,
        DSP_LONG  = 2'd1,
        I2S       = 2'd2,
        LEFT_J    = 2'd3
    } mode_e;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;
endpackage

// File: rtl/i2s_slot_counter.sv
// i2s_slot_counter: nested bit/slot position counter; exposes the next position so callers can register decodes aligned with it.
module i2s_slot_counter #(
    parameter int BIT_W  = 5,
    parameter int SLOT_W = 4
) (
    input  logic              sck_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              adv_i,
    input  logic [BIT_W-1:0]  num_bits_i,
    input  logic [SLOT_W-1:0] num_slots_i,
    output logic [BIT_W-1:0]  bit_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic              last_o,
    output logic [BIT_W-1:0]  nbit_o,
    output logic [SLOT_W-1:0] nslot_o
);
    logic [BIT_W-1:0]  r_bit;
    logic [SLOT_W-1:0] r_slot;
    logic              w_bit_wrap;
    assign w_bit_wrap = r_bit == num_bits_i;
    assign last_o     = w_bit_wrap && r_slot == num_slots_i;
    assign nbit_o     = clr_i ? '0 : !adv_i ? r_bit : w_bit_wrap ? '0 : r_bit + BIT_W'(1);
    assign nslot_o    = clr_i ? '0 : (!adv_i || !w_bit_wrap) ? r_slot :
                        (r_slot == num_slots_i) ? '0 : r_slot + SLOT_W'(1);
    assign bit_o      = r_bit;
    assign slot_o     = r_slot;
    always_ff @(posedge sck_i or posedge rst_i) begin
        if (rst_i) begin
            r_bit  <= '0;
            r_slot <= '0;
        end else begin
            r_bit  <= nbit_o;
            r_slot <= nslot_o;
        end
    end
endmodule

// File: rtl/i2s_fsync_gen.sv
// i2s_fsync_gen: I2S/TDM frame-sync generator with setup delay, drain-to-frame-end and per-frame config shadowing.
module i2s_fsync_gen
    import i2s_pkg::*;
#(
    parameter int BIT_W  = 5,
    parameter int SLOT_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              sck_i,
    input  logic              rst_i,
    input  logic              cfg_en_i,
    input  logic [1:0]        cfg_mode_i,
    input  logic [BIT_W-1:0]  cfg_num_bits_i,
    input  logic [SLOT_W-1:0] cfg_num_slots_i,
    input  logic [BIT_W-1:0]  cfg_pulse_w_i,
    input  logic [CNT_W-1:0]  cfg_setup_i,
    input  logic              cfg_pol_i,
    output logic              ws_o,
    output logic              frame_start_o,
    output logic [SLOT_W-1:0] slot_idx_o,
    output logic [BIT_W-1:0]  bit_idx_o,
    output logic              busy_o
);
    state_e            r_state, w_next;
    mode_e             r_mode, w_mode;
    logic [BIT_W-1:0]  r_nb, r_pw, w_nb, w_pw, w_nbit;
    logic [SLOT_W-1:0] r_ns, w_ns, w_nslot, w_sa;
    logic [SLOT_W:0]   w_h;
    logic [BIT_W:0]    r_pcnt, w_pcnt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pol, w_pol, r_ws, w_ws, w_raw, r_fs;
    logic              w_last, w_run, w_nrun, w_start, w_load;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !cfg_en_i ? IDLE : (cfg_setup_i != '0) ? SETUP : RUN;
            SETUP:   w_next = !cfg_en_i ? IDLE : (r_cnt == '0) ? RUN : SETUP;
            default: w_next = cfg_en_i ? RUN : w_last ? IDLE : DRAIN;
        endcase
    end
    assign w_run   = r_state == RUN || r_state == DRAIN;
    assign w_nrun  = w_next == RUN || w_next == DRAIN;
    assign w_start = !w_run && w_nrun;
    // The next position is (0,0) exactly when a frame begins; that is when new config takes effect.
    assign w_load  = w_nrun && (w_start || w_last);
    assign w_mode  = w_load ? mode_e'(cfg_mode_i) : r_mode;
    assign w_nb    = w_load ? cfg_num_bits_i : r_nb;
    assign w_ns    = w_load ? cfg_num_slots_i : r_ns;
    assign w_pw    = w_load ? cfg_pulse_w_i : r_pw;
    assign w_pol   = w_load ? cfg_pol_i : r_pol;
    i2s_slot_counter #(.BIT_W(BIT_W), .SLOT_W(SLOT_W)) u_cnt (
        .sck_i       (sck_i),
        .rst_i       (rst_i),
        .clr_i       (!w_nrun || w_start),
        .adv_i       (w_run),
        .num_bits_i  (r_nb),
        .num_slots_i (r_ns),
        .bit_o       (bit_idx_o),
        .slot_o      (slot_idx_o),
        .last_o      (w_last),
        .nbit_o      (w_nbit),
        .nslot_o     (w_nslot)
    );
    // Saturating in-frame cycle count replaces a bits*slots product for the DSP_LONG pulse.
    assign w_pcnt = (!w_nrun || w_load) ? '0 : r_pcnt[BIT_W] ? r_pcnt : r_pcnt + (BIT_W+1)'(1);
    assign w_h    = ({1'b0, w_ns} + (SLOT_W+1)'(1)) >> 1;
    assign w_sa   = (w_nbit != w_nb) ? w_nslot : (w_nslot == w_ns) ? '0 : w_nslot + SLOT_W'(1);
    assign w_raw  = (w_mode == DSP_SHORT) ? (w_nslot == '0 && w_nbit == '0) :
                    (w_mode == DSP_LONG)  ? (w_pcnt <= {1'b0, w_pw}) :
                    (w_mode == LEFT_J)    ? ({1'b0, w_nslot} < w_h) :
                                            !({1'b0, w_sa} < w_h);
    assign w_ws   = w_nrun ? w_raw ^ w_pol : cfg_pol_i;
    always_ff @(posedge sck_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_mode  <= DSP_SHORT;
            r_nb    <= '0;
            r_ns    <= '0;
            r_pw    <= '0;
            r_pol   <= 1'b0;
            r_cnt   <= '0;
            r_pcnt  <= '0;
            r_ws    <= 1'b0;
            r_fs    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == IDLE) ? cfg_setup_i - CNT_W'(1) : r_cnt - CNT_W'(1);
            r_pcnt  <= w_pcnt;
            r_ws    <= w_ws;
            r_fs    <= w_load;
            if (w_load) begin
                r_mode <= w_mode;
                r_nb   <= w_nb;
                r_ns   <= w_ns;
                r_pw   <= w_pw;
                r_pol  <= w_pol;
            end
        end
    end
    assign ws_o          = r_ws;
    assign frame_start_o = r_fs;
    assign busy_o        = r_state != IDLE;
endmodule

// File: tb/tb_i2s_fsync_gen.sv
// tb_i2s_fsync_gen: directed self-checking bench for the I2S frame-sync generator.
module tb_i2s_fsync_gen;
    localparam int BIT_W  = 5;
    localparam int SLOT_W = 4;
    localparam int CNT_W  = 16;
    logic              sck_i = 1'b0;
    logic              rst_i;
    logic              cfg_en_i;
    logic [1:0]        cfg_mode_i;
    logic [BIT_W-1:0]  cfg_num_bits_i;
    logic [SLOT_W-1:0] cfg_num_slots_i;
    logic [BIT_W-1:0]  cfg_pulse_w_i;
    logic [CNT_W-1:0]  cfg_setup_i;
    logic              cfg_pol_i;
    logic              ws_o, frame_start_o, busy_o;
    logic [SLOT_W-1:0] slot_idx_o;
    logic [BIT_W-1:0]  bit_idx_o;
    int checks = 0;
    int failures = 0;
    i2s_fsync_gen #(.BIT_W(BIT_W), .SLOT_W(SLOT_W), .CNT_W(CNT_W)) dut (
        .sck_i           (sck_i),
        .rst_i           (rst_i),
        .cfg_en_i        (cfg_en_i),
        .cfg_mode_i      (cfg_mode_i),
        .cfg_num_bits_i  (cfg_num_bits_i),
        .cfg_num_slots_i (cfg_num_slots_i),
        .cfg_pulse_w_i   (cfg_pulse_w_i),
        .cfg_setup_i     (cfg_setup_i),
        .cfg_pol_i       (cfg_pol_i),
        .ws_o            (ws_o),
        .frame_start_o   (frame_start_o),
        .slot_idx_o      (slot_idx_o),
        .bit_idx_o       (bit_idx_o),
        .busy_o          (busy_o)
    );
    always #5 sck_i = ~sck_i;
    task automatic tick();
        @(posedge sck_i);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic restart();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
    endtask
    initial begin
        rst_i = 1'b1;
        cfg_en_i = 1'b0;
        cfg_mode_i = 2'd0;
        cfg_num_bits_i = 5'd15;
        cfg_num_slots_i = 4'd1;
        cfg_pulse_w_i = '0;
        cfg_setup_i = '0;
        cfg_pol_i = 1'b0;
        #1;
        chk("rst_ws", ws_o, 0);
        chk("rst_fs", frame_start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_slot", slot_idx_o, 0);
        chk("rst_bit", bit_idx_o, 0);
        cfg_en_i = 1'b1;
        restart();
        for (int c = 0; c < 64; c++) begin
            chk("dsps_ws", ws_o, (c % 32) == 0);
            chk("dsps_fs", frame_start_o, (c % 32) == 0);
            chk("dsps_bit", bit_idx_o, c % 16);
            chk("dsps_slot", slot_idx_o, (c / 16) % 2);
            chk("dsps_busy", busy_o, 1);
            tick();
        end
        cfg_mode_i = 2'd2;
        restart();
        for (int c = 0; c < 64; c++) begin
            chk("i2s_ws", ws_o, (c % 32) >= 15 && (c % 32) < 31);
            tick();
        end
        cfg_mode_i = 2'd1;
        cfg_num_bits_i = 5'd7;
        cfg_num_slots_i = 4'd0;
        cfg_pulse_w_i = 5'd15;
        restart();
        for (int c = 0; c < 24; c++) begin
            chk("dspl_sat_ws", ws_o, 1);
            chk("dspl_sat_fs", frame_start_o, (c % 8) == 0);
            tick();
        end
        cfg_num_slots_i = 4'd1;
        cfg_pulse_w_i = 5'd2;
        restart();
        for (int c = 0; c < 32; c++) begin
            chk("dspl_ws", ws_o, (c % 16) < 3);
            tick();
        end
        cfg_mode_i = 2'd3;
        cfg_num_bits_i = 5'd3;
        cfg_num_slots_i = 4'd2;
        restart();
        for (int c = 0; c < 24; c++) begin
            chk("lj_ws", ws_o, (c % 12) < 4);
            chk("lj_slot", slot_idx_o, (c % 12) / 4);
            tick();
        end
        cfg_mode_i = 2'd0;
        cfg_num_bits_i = 5'd0;
        cfg_num_slots_i = 4'd0;
        restart();
        for (int c = 0; c < 5; c++) begin
            chk("one_fs", frame_start_o, 1);
            chk("one_ws", ws_o, 1);
            chk("one_bit", bit_idx_o, 0);
            tick();
        end
        cfg_num_bits_i = 5'd3;
        cfg_num_slots_i = 4'd1;
        cfg_setup_i = 16'd5;
        cfg_pol_i = 1'b1;
        cfg_en_i = 1'b0;
        restart();
        chk("idle_ws_pol", ws_o, 1);
        chk("idle_busy", busy_o, 0);
        cfg_en_i = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("setup_busy", busy_o, 1);
            chk("setup_ws", ws_o, 1);
            chk("setup_fs", frame_start_o, 0);
            chk("setup_bit", bit_idx_o, 0);
        end
        tick();
        chk("setup_run_fs", frame_start_o, 1);
        chk("setup_run_ws", ws_o, 0);
        cfg_en_i = 1'b0;
        restart();
        cfg_en_i = 1'b1;
        tick();
        tick();
        tick();
        chk("setup_abort_pre", busy_o, 1);
        cfg_en_i = 1'b0;
        tick();
        chk("setup_abort_busy", busy_o, 0);
        cfg_setup_i = '0;
        cfg_pol_i = 1'b0;
        cfg_mode_i = 2'd3;
        cfg_num_bits_i = 5'd7;
        cfg_num_slots_i = 4'd1;
        cfg_en_i = 1'b1;
        restart();
        tick();
        tick();
        tick();
        cfg_num_bits_i = 5'd3;
        cfg_en_i = 1'b0;
        chk("drain_bit3", bit_idx_o, 3);
        for (int c = 4; c < 16; c++) begin
            tick();
            chk("drain_bit", bit_idx_o, c % 8);
            chk("drain_slot", slot_idx_o, c / 8);
            chk("drain_busy", busy_o, 1);
            chk("drain_ws", ws_o, c < 8);
        end
        tick();
        chk("drain_end_busy", busy_o, 0);
        chk("drain_end_bit", bit_idx_o, 0);
        chk("drain_end_slot", slot_idx_o, 0);
        chk("drain_end_fs", frame_start_o, 0);
        cfg_mode_i = 2'd2;
        cfg_num_bits_i = 5'd7;
        cfg_en_i = 1'b1;
        restart();
        for (int c = 0; c < 10; c++) tick();
        chk("pre_rst_slot", slot_idx_o, 1);
        chk("pre_rst_bit", bit_idx_o, 2);
        chk("pre_rst_ws", ws_o, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_ws", ws_o, 0);
        chk("arst_fs", frame_start_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_slot", slot_idx_o, 0);
        chk("arst_bit", bit_idx_o, 0);
        rst_i = 1'b0;
        tick();
        chk("post_rst_fs", frame_start_o, 1);
        chk("post_rst_slot", slot_idx_o, 0);
        chk("post_rst_bit", bit_idx_o, 0);
        chk("post_rst_busy", busy_o, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
